// File: rtl/hw_accel_pkg.sv
// hw_accel_pkg
// Shared definitions for the 3x3 window generator. It holds the tap index
// constants, the window generator FSM state enum, and a small helper that
// maps a (row, column) position inside the 3x3 window to its tap number.
// Ports: none (package).
package hw_accel_pkg;

    localparam int P_TL     = 0;
    localparam int P_T      = 1;
    localparam int P_TR     = 2;
    localparam int P_L      = 3;
    localparam int P_CENTRE = 4;
    localparam int P_R      = 5;
    localparam int P_BL     = 6;
    localparam int P_B      = 7;
    localparam int P_BR     = 8;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_RUN,
        ST_FLUSH
    } winState_t;

    // Tap p = 3*dy + dx, with dy counting rows downward and dx counting
    // columns to the right.
    function automatic int tapIndex(input int dy, input int dx);
        return 3 * dy + dx;
    endfunction

endpackage

// File: rtl/hw_accel_line_buffer.sv
// hw_accel_line_buffer
// One line of pixel storage: a simple dual-port RAM with a synchronous write
// port and a combinational read port. Reading and writing the same address in
// one cycle returns the old contents, which lets the window generator pull the
// previous line's pixel and overwrite it with the current one in one step.
// Ports:
//   clk        - clock
//   wr_en_i    - write strobe
//   wr_addr_i  - write address (column)
//   wr_data_i  - write data
//   rd_addr_i  - read address (column)
//   rd_data_o  - read data, combinational
module hw_accel_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 640
) (
    input  logic                         clk,
    input  logic                         wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The storage array is deliberately left out of reset. Stale contents are
    // harmless because the window generator masks border taps from its own
    // counters.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/hw_accel_window_gen.sv
// hw_accel_window_gen
// Streams raster-order pixels in and emits one 3x3 neighbourhood per input
// pixel. Each window is centred on the pixel FRAME_WIDTH+1 positions behind
// the newest accepted pixel. Taps outside the frame are forced to zero. After
// the last pixel of a frame, the block stops accepting input and flushes the
// remaining FRAME_WIDTH+1 windows on its own.
// Ports:
//   clk              - clock
//   rst              - asynchronous active-high reset
//   pixel_in         - raster-order input pixel
//   pixel_in_valid   - pixel_in is valid
//   pixel_in_ready   - block can accept a pixel (low only while flushing)
//   window_out       - 3x3 window; tap p occupies [p*DATA_WIDTH +: DATA_WIDTH]
//   window_out_valid - one-cycle qualifier for window_out
//   frame_done       - pulses with the last window of a frame
module hw_accel_window_gen
    import hw_accel_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     pixel_in,
    input  logic                      pixel_in_valid,
    output logic                      pixel_in_ready,
    output logic [9*DATA_WIDTH-1:0]   window_out,
    output logic                      window_out_valid,
    output logic                      frame_done
);

    localparam int CW = $clog2(FRAME_WIDTH);
    localparam int RW = $clog2(FRAME_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

    winState_t state_q, state_d;

    logic [CW-1:0] inCol_q, inCol_d;
    logic [RW-1:0] inRow_q, inRow_d;
    logic [CW-1:0] ctrCol_q, ctrCol_d;
    logic [RW-1:0] ctrRow_q, ctrRow_d;

    logic [2:0][DATA_WIDTH-1:0] leftCol_q, midCol_q, newCol;
    logic [DATA_WIDTH-1:0]      lbTopRd, lbMidRd;

    logic [9*DATA_WIDTH-1:0] window_q, window_d;
    logic                    windowValid_q, frameDone_q;

    logic accept, step, emit, lastWin;
    logic topOut, bottomOut, leftOut, rightOut;

    // Input is refused only while the tail of the frame is being flushed.
    // During a flush the column pipeline still advances once per cycle.
    assign pixel_in_ready = (state_q != ST_FLUSH);
    assign accept         = pixel_in_valid && pixel_in_ready;
    assign step           = accept || (state_q == ST_FLUSH);

    // lbMid holds the line directly above the incoming pixel, and lbTop holds
    // the line above that. On each accept, the old lbMid entry moves down into
    // lbTop and the new pixel replaces it in lbMid.
    hw_accel_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FRAME_WIDTH)
    ) lbMid (
        .clk       (clk),
        .wr_en_i   (accept),
        .wr_addr_i (inCol_q),
        .wr_data_i (pixel_in),
        .rd_addr_i (inCol_q),
        .rd_data_o (lbMidRd)
    );

    hw_accel_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FRAME_WIDTH)
    ) lbTop (
        .clk       (clk),
        .wr_en_i   (accept),
        .wr_addr_i (inCol_q),
        .wr_data_i (lbMidRd),
        .rd_addr_i (inCol_q),
        .rd_data_o (lbTopRd)
    );

    // The freshest column of the window is taken from two line-buffer reads
    // plus the incoming pixel. While flushing there is no incoming pixel, so
    // the bottom entry is zero; it is always masked in that phase anyway.
    always_comb begin
        newCol    = '0;
        newCol[0] = lbTopRd;
        newCol[1] = lbMidRd;
        newCol[2] = (state_q == ST_FLUSH) ? '0 : pixel_in;
    end

    // FSM next state and counter bookkeeping. The input counters track the
    // position of the next pixel to arrive; during a flush the column counter
    // keeps walking so the line buffers are read for the virtual row below the
    // frame. The centre counters track the window being emitted and drive all
    // border masking. Because of that, stale buffer contents after a reset or
    // from a previous frame never appear in the output.
    always_comb begin
        state_d  = state_q;
        inCol_d  = inCol_q;
        inRow_d  = inRow_q;
        ctrCol_d = ctrCol_q;
        ctrRow_d = ctrRow_q;
        emit     = 1'b0;
        lastWin  = 1'b0;

        if (step) begin
            if (inCol_q == COL_LAST) begin
                inCol_d = '0;
                if (accept) begin
                    inRow_d = (inRow_q == ROW_LAST) ? '0 : inRow_q + 1'b1;
                end
            end else begin
                inCol_d = inCol_q + 1'b1;
            end
        end

        case (state_q)
            ST_FILL: begin
                if (accept && (inRow_q == RW'(1)) && (inCol_q == '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                emit = accept;
                if (accept && (inRow_q == ROW_LAST) && (inCol_q == COL_LAST)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                emit = 1'b1;
                if ((ctrRow_q == ROW_LAST) && (ctrCol_q == COL_LAST)) begin
                    lastWin = 1'b1;
                    state_d = ST_FILL;
                    inCol_d = '0;
                    inRow_d = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (emit) begin
            if (ctrCol_q == COL_LAST) begin
                ctrCol_d = '0;
                ctrRow_d = (ctrRow_q == ROW_LAST) ? '0 : ctrRow_q + 1'b1;
            end else begin
                ctrCol_d = ctrCol_q + 1'b1;
            end
        end
    end

    // Assemble the next window from the left and middle column registers and
    // the fresh column, then zero any tap that falls outside the frame. When
    // the centre is in the last column, the fresh column already belongs to
    // the next line, so it is masked as the right border. That is what
    // prevents wrap between lines.
    assign topOut    = (ctrRow_q == '0);
    assign bottomOut = (ctrRow_q == ROW_LAST);
    assign leftOut   = (ctrCol_q == '0);
    assign rightOut  = (ctrCol_q == COL_LAST);

    always_comb begin
        window_d = '0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                if (!((dy == 0 && topOut) || (dy == 2 && bottomOut) ||
                      (dx == 0 && leftOut) || (dx == 2 && rightOut))) begin
                    if (dx == 0) begin
                        window_d[tapIndex(dy, dx)*DATA_WIDTH +: DATA_WIDTH] = leftCol_q[dy];
                    end else if (dx == 1) begin
                        window_d[tapIndex(dy, dx)*DATA_WIDTH +: DATA_WIDTH] = midCol_q[dy];
                    end else begin
                        window_d[tapIndex(dy, dx)*DATA_WIDTH +: DATA_WIDTH] = newCol[dy];
                    end
                end
            end
        end
    end

    // Control registers: FSM state plus input and centre position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FILL;
            inCol_q  <= '0;
            inRow_q  <= '0;
            ctrCol_q <= '0;
            ctrRow_q <= '0;
        end else begin
            state_q  <= state_d;
            inCol_q  <= inCol_d;
            inRow_q  <= inRow_d;
            ctrCol_q <= ctrCol_d;
            ctrRow_q <= ctrRow_d;
        end
    end

    // Datapath registers. The column pipeline shifts on every accept or flush
    // step, so gaps in the input freeze it in place. The output window is
    // registered, giving one cycle of latency from accept to window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leftCol_q     <= '0;
            midCol_q      <= '0;
            window_q      <= '0;
            windowValid_q <= 1'b0;
            frameDone_q   <= 1'b0;
        end else begin
            if (step) begin
                leftCol_q <= midCol_q;
                midCol_q  <= newCol;
            end
            if (emit) begin
                window_q <= window_d;
            end
            windowValid_q <= emit;
            frameDone_q   <= lastWin;
        end
    end

    assign window_out       = window_q;
    assign window_out_valid = windowValid_q;
    assign frame_done       = frameDone_q;

endmodule

// File: tb/tb_hw_accel_window_gen.sv
// tb_hw_accel_window_gen
// Directed bench for hw_accel_window_gen on a 4x3 frame whose pixels carry
// the value index+1. The expected windows below are worked out by hand from
// the frame:
//   row0:  1  2  3  4
//   row1:  5  6  7  8
//   row2:  9 10 11 12
module tb_hw_accel_window_gen;
    import hw_accel_pkg::*;

    localparam int DW   = 8;
    localparam int FW   = 4;
    localparam int FH   = 3;
    localparam int NPIX = FW * FH;
    localparam int NWIN = FW * FH;
    localparam int NRUN = NWIN - (FW + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   pixel_in;
    logic            pixel_in_valid;
    logic            pixel_in_ready;
    logic [9*DW-1:0] window_out;
    logic            window_out_valid;
    logic            frame_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] expTaps [NWIN][9] = '{
        '{0, 0, 0,   0,  1,  2,   0,  5,  6},
        '{0, 0, 0,   1,  2,  3,   5,  6,  7},
        '{0, 0, 0,   2,  3,  4,   6,  7,  8},
        '{0, 0, 0,   3,  4,  0,   7,  8,  0},
        '{0, 1, 2,   0,  5,  6,   0,  9, 10},
        '{1, 2, 3,   5,  6,  7,   9, 10, 11},
        '{2, 3, 4,   6,  7,  8,  10, 11, 12},
        '{3, 4, 0,   7,  8,  0,  11, 12,  0},
        '{0, 5, 6,   0,  9, 10,   0,  0,  0},
        '{5, 6, 7,   9, 10, 11,   0,  0,  0},
        '{6, 7, 8,  10, 11, 12,   0,  0,  0},
        '{7, 8, 0,  11, 12,  0,   0,  0,  0}
    };

    hw_accel_window_gen #(
        .DATA_WIDTH   (DW),
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pixel_in         (pixel_in),
        .pixel_in_valid   (pixel_in_valid),
        .pixel_in_ready   (pixel_in_ready),
        .window_out       (window_out),
        .window_out_valid (window_out_valid),
        .frame_done       (frame_done)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Turn one row of the hand-computed tap table into a packed window.
    function automatic logic [71:0] expWindow(input int idx);
        logic [71:0] w;
        w = '0;
        for (int p = 0; p < 9; p++) begin
            w[p*8 +: 8] = expTaps[idx][p];
        end
        return w;
    endfunction

    // One comparison point: count it and report any mismatch.
    task automatic checkOutput(input string tag, input logic [71:0] observed,
                               input logic [71:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of input, then settle just after the rising edge.
    task automatic applyStimulus(input logic [7:0] value, input logic valid);
        pixel_in       = value;
        pixel_in_valid = valid;
        @(posedge clk);
        #1;
    endtask

    // Push one frame through the DUT and check every cycle. The checks cover
    // ready against the bench's own view of the flush, every emitted window
    // against the table, the accept that produced each window, and the
    // frame_done pulse.
    // gapped: valid follows the pattern 1,0,0,1,0,0...
    // hold99: valid stays high with value 99 while the DUT is flushing.
    task automatic runFrame(input string name, input bit gapped, input bit hold99);
        int  k;
        int  winIdx;
        int  readyLow;
        int  cyc;
        bit  sendNow;
        bit  accepted;
        k        = 0;
        winIdx   = 0;
        readyLow = 0;
        cyc      = 0;
        while (winIdx < NWIN && cyc < 200) begin
            sendNow = (k < NPIX) ? (!gapped || (cyc % 3 == 0)) : hold99;
            checkOutput({name, " ready"}, 72'(pixel_in_ready), 72'(k < NPIX));
            if (!pixel_in_ready) begin
                readyLow++;
            end
            accepted = sendNow && (k < NPIX);
            applyStimulus((k < NPIX) ? 8'(k + 1) : 8'd99, sendNow);
            if (accepted) begin
                k++;
            end
            cyc++;
            if (window_out_valid) begin
                checkOutput({name, " taps"}, window_out, expWindow(winIdx));
                checkOutput({name, " frame_done"}, 72'(frame_done), 72'(winIdx == NWIN - 1));
                checkOutput({name, " emit point"},
                            72'((accepted ? 100 : 0) + k),
                            72'((winIdx < NRUN) ? (100 + winIdx + FW + 2) : NPIX));
                winIdx++;
            end else begin
                checkOutput({name, " idle frame_done"}, 72'(frame_done), 72'(0));
            end
        end
        checkOutput({name, " window count"}, 72'(winIdx), 72'(NWIN));
        checkOutput({name, " ready low cycles"}, 72'(readyLow), 72'(FW + 1));
    endtask

    // Directed sequence: reset values, plain ramp, gapped ramp with junk
    // driven during the flush, a back-to-back frame, a mid-frame reset and a
    // clean frame after it.
    initial begin
        rst            = 1'b1;
        pixel_in       = '0;
        pixel_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset window_out", window_out, 72'(0));
        checkOutput("reset valid", 72'(window_out_valid), 72'(0));
        checkOutput("reset frame_done", 72'(frame_done), 72'(0));
        checkOutput("reset ready", 72'(pixel_in_ready), 72'(1));
        rst = 1'b0;
        applyStimulus(8'd0, 1'b0);
        checkOutput("post-reset ready", 72'(pixel_in_ready), 72'(1));
        checkOutput("post-reset valid", 72'(window_out_valid), 72'(0));

        runFrame("ramp", 1'b0, 1'b0);
        runFrame("gapped", 1'b1, 1'b1);
        runFrame("after99", 1'b0, 1'b0);

        for (int v = 1; v <= 7; v++) begin
            applyStimulus(8'(v), 1'b1);
            if (v == 6) begin
                checkOutput("partial first valid", 72'(window_out_valid), 72'(1));
                checkOutput("partial first centre", 72'(window_out[P_CENTRE*DW +: DW]), 72'(1));
            end
            if (v == 7) begin
                checkOutput("partial second centre", 72'(window_out[P_CENTRE*DW +: DW]), 72'(2));
            end
        end
        pixel_in_valid = 1'b0;
        rst            = 1'b1;
        #2;
        checkOutput("midreset window_out", window_out, 72'(0));
        checkOutput("midreset valid", 72'(window_out_valid), 72'(0));
        checkOutput("midreset frame_done", 72'(frame_done), 72'(0));
        checkOutput("midreset ready", 72'(pixel_in_ready), 72'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(8'd0, 1'b0);

        runFrame("clean", 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'd0, 1'b0);
            checkOutput("tail idle valid", 72'(window_out_valid), 72'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
